// File: rtl/bcd_count_ctrl.sv
// Command-driven sequencer for a cascaded BCD counter: CLEAR/LOAD/START/STOP
// over valid/ready, prescaled increments, terminal-value stop and wrap report.
//
// state | meaning
// IDLE  | counter parked, accepts any command
// RUN   | prescaler advancing, count increments on each tick
// HOLD  | count and prescaler frozen after STOP
// DONE  | one-cycle terminal state, count equals limit, commands refused
module bcd_count_ctrl #(
  parameter int DIGITS   = 2,
  parameter int TICK_DIV = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [4*DIGITS-1:0] cmd_data,
  output logic [4*DIGITS-1:0] cnt_o,
  output logic                running_o,
  output logic                done_o,
  output logic                wrap_o
);

  localparam int W  = 4 * DIGITS;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);

  localparam logic [1:0] OP_CLEAR = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_START = 2'b10;
  localparam logic [1:0] OP_STOP  = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD, S_DONE} state_t;

  state_t        state_q, state_nxt;
  logic [W-1:0]  cnt_q, cnt_nxt;
  logic [W-1:0]  lim_q, lim_nxt;
  logic [PW-1:0] presc_q, presc_nxt;
  logic          wrap_q, wrap_nxt;

  logic [W-1:0]  data_san;
  logic [W-1:0]  cnt_inc;
  logic          all_nines;
  logic          tick;
  logic          accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      lim_q   <= '0;
      presc_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      lim_q   <= lim_nxt;
      presc_q <= presc_nxt;
      wrap_q  <= wrap_nxt;
    end
  end

  // Operand clamp and ripple-carry BCD increment; final carry means all-9s.
  always_comb begin
    logic carry;
    data_san = '0;
    cnt_inc  = '0;
    carry    = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      data_san[4*i +: 4] = (cmd_data[4*i +: 4] > 4'd9) ? 4'd9 : cmd_data[4*i +: 4];
      if (carry && cnt_q[4*i +: 4] == 4'd9) begin
        cnt_inc[4*i +: 4] = 4'd0;
      end else begin
        cnt_inc[4*i +: 4] = cnt_q[4*i +: 4] + {3'b000, carry};
        carry = 1'b0;
      end
    end
    all_nines = carry;
  end

  assign tick   = (state_q == S_RUN) && (presc_q == PS_LAST);
  assign accept = cmd_valid && cmd_ready;

  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    lim_nxt   = lim_q;
    wrap_nxt  = 1'b0;
    if (state_q == S_RUN) presc_nxt = tick ? '0 : presc_q + PW'(1);
    else                  presc_nxt = presc_q;

    // An accepted command beats a coincident tick; the increment is dropped.
    if (accept) begin
      case (cmd_op)
        OP_CLEAR: begin
          cnt_nxt   = '0;
          presc_nxt = '0;
          state_nxt = S_IDLE;
        end
        OP_LOAD: begin
          cnt_nxt   = data_san;
          presc_nxt = '0;
          state_nxt = S_IDLE;
        end
        OP_START: begin
          lim_nxt   = data_san;
          state_nxt = (cnt_q == data_san) ? S_DONE : S_RUN;
        end
        default: begin
          if (state_q == S_RUN) state_nxt = S_HOLD;
        end
      endcase
    end else if (state_q == S_DONE) begin
      state_nxt = S_IDLE;
    end else if (tick) begin
      cnt_nxt  = cnt_inc;
      wrap_nxt = all_nines;
      if (cnt_inc == lim_q) state_nxt = S_DONE;
    end
  end

  always_comb begin
    cmd_ready = (state_q != S_DONE);
    running_o = (state_q == S_RUN);
    done_o    = (state_q == S_DONE);
    cnt_o     = cnt_q;
    wrap_o    = wrap_q;
  end

endmodule

// File: tb/tb_bcd_count_ctrl.sv
// Bench for bcd_count_ctrl: decimal-arithmetic reference model checked every
// cycle, directed scenarios with literal expectations, then random commands.
module tb_bcd_count_ctrl;
  localparam int D    = 2;
  localparam int TD   = 4;
  localparam int W    = 4 * D;
  localparam int MAXV = 10 ** D;

  localparam logic [1:0] CLR = 2'b00, LD = 2'b01, STA = 2'b10, STP = 2'b11;

  logic         tb_clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [1:0]   cmd_op = 2'b00;
  logic [W-1:0] cmd_data = '0;
  logic [W-1:0] cnt_o;
  logic         running_o, done_o, wrap_o;

  always #5 tb_clk = ~tb_clk;

  bcd_count_ctrl #(.DIGITS(D), .TICK_DIV(TD)) dut (
    .clk(tb_clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cnt_o(cnt_o),
    .running_o(running_o), .done_o(done_o), .wrap_o(wrap_o)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic int san_dec(input logic [W-1:0] d);
    int v, p, dig;
    v = 0;
    p = 1;
    for (int i = 0; i < D; i++) begin
      dig = int'(d[4*i +: 4]);
      if (dig > 9) dig = 9;
      v += dig * p;
      p *= 10;
    end
    return v;
  endfunction

  // Reference: count as a plain integer modulo 10^D, phase counts RUN cycles.
  localparam int M_IDLE = 0, M_RUN = 1, M_HOLD = 2, M_DONE = 3;
  int m_cnt = 0, m_lim = 0, m_ph = 0, m_mode = M_IDLE;
  bit m_wrap = 0, m_live = 0;

  always @(posedge tb_clk) begin
    bit acc, tck;
    if (rst) begin
      m_cnt = 0; m_lim = 0; m_ph = 0; m_mode = M_IDLE; m_wrap = 0; m_live = 1;
    end else begin
      acc = cmd_valid && (m_mode != M_DONE);
      tck = (m_mode == M_RUN) && (m_ph == TD - 1);
      if (m_mode == M_RUN) m_ph = (m_ph + 1) % TD;
      m_wrap = 0;
      if (acc) begin
        if (cmd_op == CLR) begin
          m_cnt = 0; m_ph = 0; m_mode = M_IDLE;
        end else if (cmd_op == LD) begin
          m_cnt = san_dec(cmd_data); m_ph = 0; m_mode = M_IDLE;
        end else if (cmd_op == STA) begin
          m_lim = san_dec(cmd_data);
          m_mode = (m_cnt == m_lim) ? M_DONE : M_RUN;
        end else if (m_mode == M_RUN) begin
          m_mode = M_HOLD;
        end
      end else if (m_mode == M_DONE) begin
        m_mode = M_IDLE;
      end else if (tck) begin
        m_wrap = (m_cnt == MAXV - 1);
        m_cnt = (m_cnt + 1) % MAXV;
        if (m_cnt == m_lim) m_mode = M_DONE;
      end
    end
  end

  always @(negedge tb_clk) begin
    if (m_live) begin
      chk("cnt_o",     cnt_o,     to_bcd(m_cnt));
      chk("running_o", running_o, m_mode == M_RUN);
      chk("done_o",    done_o,    m_mode == M_DONE);
      chk("wrap_o",    wrap_o,    m_wrap);
      chk("cmd_ready", cmd_ready, m_mode != M_DONE);
    end
  end

  task automatic send(input logic [1:0] op, input logic [W-1:0] d);
    cmd_op = op;
    cmd_data = d;
    cmd_valid = 1'b1;
    @(posedge tb_clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_cnt(input logic [W-1:0] v, input string nm);
    int n;
    n = 0;
    do begin
      @(negedge tb_clk);
      n++;
    end while (cnt_o !== v && n < 200);
    chk(nm, cnt_o, v);
  endtask

  initial begin
    int n;
    bit both;
    logic [W-1:0] prev;
    logic [W-1:0] seen[$];
    bit wrap_seen[$];

    // 1: reset, LOAD
    repeat (2) @(posedge tb_clk);
    @(negedge tb_clk);
    chk("rst_cnt", cnt_o, 8'h00);
    chk("rst_run", running_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    rst = 1'b0;
    @(negedge tb_clk);
    send(LD, 8'h37);
    @(negedge tb_clk);
    chk("t1_cnt", cnt_o, 8'h37);
    chk("t1_run", running_o, 1'b0);

    // 2: count 0 -> 0x12, 48 cycles after running rises
    send(CLR, 8'h00);
    send(STA, 8'h12);
    n = 0;
    do begin
      @(negedge tb_clk);
      if (!done_o) n++;
    end while (!done_o && n < 200);
    chk("t2_cycles", n, 48);
    chk("t2_cnt", cnt_o, 8'h12);
    chk("t2_ready", cmd_ready, 1'b0);
    @(negedge tb_clk);
    chk("t2_run_after", running_o, 1'b0);
    chk("t2_hold_cnt", cnt_o, 8'h12);

    // 3: wrap then done
    send(LD, 8'h98);
    send(STA, 8'h01);
    prev = cnt_o;
    both = 0;
    n = 0;
    do begin
      @(negedge tb_clk);
      n++;
      if (wrap_o && done_o) both = 1;
      if (cnt_o !== prev) begin
        seen.push_back(cnt_o);
        wrap_seen.push_back(wrap_o);
        prev = cnt_o;
      end
    end while (!done_o && n < 100);
    chk("t3_nchg", seen.size(), 3);
    if (seen.size() == 3) begin
      chk("t3_s0", seen[0], 8'h99);
      chk("t3_s1", seen[1], 8'h00);
      chk("t3_s2", seen[2], 8'h01);
      chk("t3_wrap_at0", wrap_seen[1], 1'b1);
      chk("t3_wrap_at1", wrap_seen[2], 1'b0);
    end
    chk("t3_both", both, 1'b0);

    // 4: STOP freezes count and phase; resume mid-period
    @(negedge tb_clk);
    send(CLR, 8'h00);
    send(STA, 8'h50);
    wait_cnt(8'h02, "t4_reach");
    @(negedge tb_clk);
    send(STP, 8'h00);
    for (int i = 0; i < 20; i++) begin
      @(negedge tb_clk);
      chk("t4_frozen", cnt_o, 8'h02);
    end
    send(STA, 8'h50);
    @(negedge tb_clk);
    chk("t4_a", cnt_o, 8'h02);
    @(negedge tb_clk);
    chk("t4_b", cnt_o, 8'h02);
    @(negedge tb_clk);
    chk("t4_c", cnt_o, 8'h03);

    // 5: immediate done, clamp, STOP in IDLE
    send(LD, 8'h25);
    send(STA, 8'h25);
    @(negedge tb_clk);
    chk("t5_done", done_o, 1'b1);
    chk("t5_cnt", cnt_o, 8'h25);
    @(negedge tb_clk);
    chk("t5_done_end", done_o, 1'b0);
    send(LD, 8'hAF);
    @(negedge tb_clk);
    chk("t5_clamp", cnt_o, 8'h99);
    send(STP, 8'h00);
    @(negedge tb_clk);
    chk("t5_stop_idle", running_o, 1'b0);
    chk("t5_stop_cnt", cnt_o, 8'h99);

    // 6: reset beats LOAD; command beats tick
    send(CLR, 8'h00);
    send(STA, 8'h50);
    repeat (6) @(negedge tb_clk);
    rst = 1'b1;
    cmd_op = LD;
    cmd_data = 8'h44;
    cmd_valid = 1'b1;
    @(posedge tb_clk);
    #1;
    rst = 1'b0;
    cmd_valid = 1'b0;
    @(negedge tb_clk);
    chk("t6_rst_cnt", cnt_o, 8'h00);
    chk("t6_rst_run", running_o, 1'b0);
    send(STA, 8'h50);
    wait_cnt(8'h01, "t6_reach1");
    repeat (3) @(negedge tb_clk);
    send(LD, 8'h70);
    @(negedge tb_clk);
    chk("t6_ld_tick", cnt_o, 8'h70);
    send(STA, 8'h90);
    wait_cnt(8'h71, "t6_reach71");
    repeat (3) @(negedge tb_clk);
    send(CLR, 8'h00);
    @(negedge tb_clk);
    chk("t6_clr_tick", cnt_o, 8'h00);
    chk("t6_clr_run", running_o, 1'b0);

    // Random command traffic against the model
    for (int c = 0; c < 3000; c++) begin
      @(posedge tb_clk);
      #1;
      rst = ($urandom_range(0, 299) == 0);
      cmd_valid = ($urandom_range(0, 5) == 0);
      cmd_op = 2'($urandom_range(0, 3));
      for (int i = 0; i < D; i++)
        cmd_data[4*i +: 4] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15))
                                                          : 4'($urandom_range(0, 9));
    end
    @(posedge tb_clk);
    #1;
    rst = 1'b0;
    cmd_valid = 1'b0;
    @(negedge tb_clk);
    @(negedge tb_clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
